// File: rtl/multi_correlator_if.sv
// Byte-stream result port of the correlator: registered data/valid from the
// producer, ready from the consumer.
interface multi_correlator_if;
    logic [7:0] bp_data;
    logic       bp_valid;
    logic       bp_ready;

    modport master (output bp_data, output bp_valid, input bp_ready);
    modport slave  (input bp_data, input bp_valid, output bp_ready);
endinterface

// File: rtl/multi_correlator.sv
// Multi-pair windowed X/Y/intersection/symmetric-difference counter that
// snapshots each window into a scaled byte packet on a valid/ready stream.
module multi_correlator #(
    parameter int N_PAIRS               = 2,
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int WLE_W                 = $clog2(MAX_WINDOW_LENGTH_EXP + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cg,
    input  logic               i_sampleStrobe,
    input  logic [N_PAIRS-1:0] i_x,
    input  logic [N_PAIRS-1:0] i_y,
    input  logic [WLE_W-1:0]   i_windowLengthExp,
    input  logic               i_enable,
    input  logic               i_oneShot,
    multi_correlator_if.master bp,
    output logic               o_busy,
    output logic [7:0]         o_nDropped
);
    localparam int CW = MAX_WINDOW_LENGTH_EXP + 1;
    localparam int NB = 1 + 4 * N_PAIRS;
    localparam int IW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} cap_state_t;
    typedef enum logic {E_IDLE, E_SEND} emit_state_t;

    cap_state_t     cap_q, cap_d;
    emit_state_t    emit_q, emit_d;
    logic [WLE_W-1:0] e_q, e_d;
    logic           one_q, one_d;
    logic [CW-1:0]  t_q, t_d;
    logic [CW-1:0]  cntx_q [N_PAIRS];
    logic [CW-1:0]  cntx_d [N_PAIRS];
    logic [CW-1:0]  cnty_q [N_PAIRS];
    logic [CW-1:0]  cnty_d [N_PAIRS];
    logic [CW-1:0]  cnti_q [N_PAIRS];
    logic [CW-1:0]  cnti_d [N_PAIRS];
    logic [CW-1:0]  cnts_q [N_PAIRS];
    logic [CW-1:0]  cnts_d [N_PAIRS];
    logic [CW-1:0]  nx [N_PAIRS];
    logic [CW-1:0]  ny [N_PAIRS];
    logic [CW-1:0]  ni [N_PAIRS];
    logic [CW-1:0]  ns [N_PAIRS];
    logic [7:0]     win_q, win_d;
    logic [7:0]     drop_q, drop_d;
    logic [7:0]     pkt_q [NB];
    logic [7:0]     pkt_d [NB];
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           accept, last_byte, free, win_end;
    logic [CW-1:0]  win_mask;

    function automatic logic [7:0] scale_sat(input logic [CW-1:0] c, input logic [WLE_W-1:0] e);
        logic [CW+7:0] w;
        int            ei;
        ei = int'(e);
        w  = {8'd0, c};
        if (ei >= 8) w = w >> (ei - 8);
        else         w = w << (8 - ei);
        return (w > (CW+8)'(255)) ? 8'hFF : w[7:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        cap_d   = cap_q;
        emit_d  = emit_q;
        e_d     = e_q;
        one_d   = one_q;
        t_d     = t_q;
        cntx_d  = cntx_q;
        cnty_d  = cnty_q;
        cnti_d  = cnti_q;
        cnts_d  = cnts_q;
        win_d   = win_q;
        drop_d  = drop_q;
        pkt_d   = pkt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        win_end = 1'b0;
        accept    = valid_q && bp.bp_ready;
        last_byte = (idx_q == IW'(NB - 1));
        free      = (emit_q == E_IDLE) || (accept && last_byte);
        win_mask  = (CW'(1) << e_q) - CW'(1);
        for (int p = 0; p < N_PAIRS; p++) begin
            nx[p] = cntx_q[p] + CW'(i_x[p]);
            ny[p] = cnty_q[p] + CW'(i_y[p]);
            ni[p] = cnti_q[p] + CW'(i_x[p] & i_y[p]);
            ns[p] = cnts_q[p] + CW'(i_x[p] ^ i_y[p]);
        end

        if (i_cg) begin
            if (emit_q == E_SEND && accept) begin
                if (last_byte) begin
                    emit_d  = E_IDLE;
                    valid_d = 1'b0;
                end else begin
                    idx_d  = idx_q + IW'(1);
                    data_d = pkt_q[idx_q + IW'(1)];
                end
            end

            unique case (cap_q)
                IDLE: begin
                    if (i_enable) begin
                        cap_d = COUNT;
                        e_d   = (i_windowLengthExp > WLE_W'(MAX_WINDOW_LENGTH_EXP))
                                ? WLE_W'(MAX_WINDOW_LENGTH_EXP) : i_windowLengthExp;
                        one_d = i_oneShot;
                    end
                end
                COUNT: begin
                    if (!i_enable) begin
                        cap_d = IDLE;
                        t_d   = '0;
                        for (int p = 0; p < N_PAIRS; p++) begin
                            cntx_d[p] = '0; cnty_d[p] = '0; cnti_d[p] = '0; cnts_d[p] = '0;
                        end
                    end else if (i_sampleStrobe) begin
                        if (t_q == win_mask) begin
                            win_end = 1'b1;
                            t_d     = '0;
                            for (int p = 0; p < N_PAIRS; p++) begin
                                cntx_d[p] = '0; cnty_d[p] = '0; cnti_d[p] = '0; cnts_d[p] = '0;
                            end
                            if (one_q) cap_d = DONE;
                        end else begin
                            t_d    = t_q + CW'(1);
                            cntx_d = nx;
                            cnty_d = ny;
                            cnti_d = ni;
                            cnts_d = ns;
                        end
                    end
                end
                DONE: begin
                    if (!i_enable) cap_d = IDLE;
                end
                default: cap_d = IDLE;
            endcase

            // A snapshot takes the emitter only if it is idle or finishing now.
            if (win_end) begin
                win_d = win_q + 8'd1;
                if (free) begin
                    pkt_d[0] = win_q;
                    for (int p = 0; p < N_PAIRS; p++) begin
                        pkt_d[1 + 4*p] = scale_sat(nx[p], e_q);
                        pkt_d[2 + 4*p] = scale_sat(ny[p], e_q);
                        pkt_d[3 + 4*p] = scale_sat(ni[p], e_q);
                        pkt_d[4 + 4*p] = scale_sat(ns[p], e_q);
                    end
                    data_d  = win_q;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    emit_d  = E_SEND;
                end else begin
                    drop_d = sat_inc8(drop_q);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_q   <= IDLE;
            emit_q  <= E_IDLE;
            e_q     <= '0;
            one_q   <= 1'b0;
            t_q     <= '0;
            win_q   <= '0;
            drop_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            for (int p = 0; p < N_PAIRS; p++) begin
                cntx_q[p] <= '0; cnty_q[p] <= '0; cnti_q[p] <= '0; cnts_q[p] <= '0;
            end
            for (int b = 0; b < NB; b++) pkt_q[b] <= '0;
        end else begin
            cap_q   <= cap_d;
            emit_q  <= emit_d;
            e_q     <= e_d;
            one_q   <= one_d;
            t_q     <= t_d;
            win_q   <= win_d;
            drop_q  <= drop_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cntx_q  <= cntx_d;
            cnty_q  <= cnty_d;
            cnti_q  <= cnti_d;
            cnts_q  <= cnts_d;
            pkt_q   <= pkt_d;
        end
    end

    assign bp.bp_data  = data_q;
    assign bp.bp_valid = valid_q;
    assign o_nDropped  = drop_q;
    assign o_busy      = (cap_q == COUNT) || (emit_q != E_IDLE);
endmodule

// File: tb/tb_multi_correlator.sv
// Randomized and directed bench for multi_correlator against a cycle-level
// behavioural model built from integer counts and a byte queue.
module tb_multi_correlator;
    localparam int NP   = 2;
    localparam int MAXE = 16;
    localparam int WW   = $clog2(MAXE + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cg, strobe, en, one, ready;
    logic [NP-1:0] x, y;
    logic [WW-1:0] wle;
    logic [7:0]    ndrop;
    logic          busy;

    multi_correlator_if bpif();
    assign bpif.bp_ready = ready;

    multi_correlator #(.N_PAIRS(NP), .MAX_WINDOW_LENGTH_EXP(MAXE)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_sampleStrobe(strobe),
        .i_x(x), .i_y(y), .i_windowLengthExp(wle), .i_enable(en),
        .i_oneShot(one), .bp(bpif), .o_busy(busy), .o_nDropped(ndrop)
    );

    // Model state: 0 = idle, 1 = counting, 2 = one-shot finished.
    int m_cap = 0, m_e = 0, m_one = 0, m_t = 0, m_win = 0, m_drop = 0;
    int m_cx[NP], m_cy[NP], m_ci[NP], m_cs[NP];
    int m_q[$];
    int rx[$];
    int errs = 0, checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            if (errs <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int scaled(int c, int e);
        int v;
        if (e >= 8) v = c / (1 << (e - 8));
        else        v = c * (1 << (8 - e));
        return (v > 255) ? 255 : v;
    endfunction

    task automatic m_clear();
        m_t = 0;
        for (int p = 0; p < NP; p++) begin
            m_cx[p] = 0; m_cy[p] = 0; m_ci[p] = 0; m_cs[p] = 0;
        end
    endtask

    task automatic model_step();
        bit acc, fr;
        if (rst) begin
            m_cap = 0; m_win = 0; m_drop = 0; m_clear(); m_q.delete();
            return;
        end
        if (!cg) return;
        acc = (m_q.size() > 0) && ready;
        fr  = (m_q.size() == 0) || (acc && m_q.size() == 1);
        if (acc) begin
            rx.push_back(int'(bpif.bp_data));
            void'(m_q.pop_front());
        end
        if (m_cap == 0) begin
            if (en) begin
                m_cap = 1; m_e = (int'(wle) > MAXE) ? MAXE : int'(wle); m_one = one; m_clear();
            end
        end else if (m_cap == 1) begin
            if (!en) begin
                m_cap = 0; m_clear();
            end else if (strobe) begin
                for (int p = 0; p < NP; p++) begin
                    m_cx[p] += x[p]; m_cy[p] += y[p];
                    m_ci[p] += (x[p] & y[p]); m_cs[p] += (x[p] ^ y[p]);
                end
                if (m_t == (1 << m_e) - 1) begin
                    if (fr) begin
                        m_q.push_back(m_win);
                        for (int p = 0; p < NP; p++) begin
                            m_q.push_back(scaled(m_cx[p], m_e));
                            m_q.push_back(scaled(m_cy[p], m_e));
                            m_q.push_back(scaled(m_ci[p], m_e));
                            m_q.push_back(scaled(m_cs[p], m_e));
                        end
                    end else begin
                        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    end
                    m_win = (m_win + 1) % 256;
                    m_clear();
                    if (m_one) m_cap = 2;
                end else begin
                    m_t++;
                end
            end
        end else begin
            if (!en) m_cap = 0;
        end
    endtask

    task automatic cyc();
        check_val("valid", bpif.bp_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check_val("data", bpif.bp_data, m_q[0]);
        check_val("busy", busy, (m_cap == 1) || (m_q.size() > 0));
        check_val("ndropped", ndrop, m_drop);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    int exp1[9] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h00};
    logic [7:0] d0;
    int w0;

    initial begin
        rst = 1'b1; cg = 1'b1; strobe = 1'b0; en = 1'b0; one = 1'b0; ready = 1'b1;
        x = '0; y = '0; wle = '0;
        @(posedge clk); #1;
        cyc();
        rst = 1'b0;
        check_val("rst_data", bpif.bp_data, 0);
        check_val("rst_valid", bpif.bp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ndropped", ndrop, 0);

        // Back-to-back windows, e=2
        rx.delete(); wle = 2; en = 1'b1; strobe = 1'b1;
        for (int k = 0; k < 16; k++) begin
            x = {(m_t == 0 || m_t == 2), 1'b1};
            y = {(m_t == 0 || m_t == 2), 1'b0};
            cyc();
        end
        en = 1'b0; x = '0; y = '0;
        run(20);
        check_val("pkt1_len", rx.size() >= 9, 1);
        if (rx.size() >= 9)
            for (int i = 0; i < 9; i++) check_val($sformatf("pkt1_b%0d", i), rx[i], exp1[i]);

        // e>=8 scaling and saturation
        do_reset();
        rx.delete(); wle = 10; en = 1'b1; strobe = 1'b1; w0 = m_win;
        for (int k = 0; k < 2070; k++) begin
            x[0] = (m_win == w0) ? (m_t < 300) : 1'b1;
            x[1] = 1'($urandom_range(0, 1)); y = '0;
            cyc();
        end
        en = 1'b0; run(12);
        check_val("scale_len", rx.size() >= 18, 1);
        if (rx.size() >= 18) begin
            check_val("scale_x300", rx[1], 8'h4B);
            check_val("scale_xfull", rx[10], 8'hFF);
        end

        // Drop accounting, e=0 with ready low
        do_reset();
        rx.delete(); wle = 0; ready = 1'b0; en = 1'b1; strobe = 1'b1; x = 2'b01; y = 2'b10;
        run(300);
        check_val("drop_sat", ndrop, 255);
        check_val("drop_hold_valid", bpif.bp_valid, 1);
        check_val("drop_hold_data", bpif.bp_data, 0);
        ready = 1'b1; run(12);
        check_val("drop_still_sat", ndrop, 255);
        if (rx.size() >= 10) check_val("drop_next_not_01", rx[9] == 1, 0);
        else check_val("drop_rx_len", rx.size(), 10);
        en = 1'b0; run(20);

        // One-shot, e=3
        do_reset();
        rx.delete(); wle = 3; one = 1'b1; en = 1'b1; strobe = 1'b1; x = 2'b11; y = 2'b01;
        run(40);
        check_val("oneshot_len", rx.size(), 9);
        check_val("oneshot_busy", busy, 0);
        en = 1'b0; cyc(); en = 1'b1; run(30);
        check_val("oneshot_rearm_len", rx.size(), 18);
        en = 1'b0; one = 1'b0; run(5);

        // Enable dropped mid-window, e=4
        do_reset();
        rx.delete(); wle = 4; en = 1'b1; strobe = 1'b1;
        for (int k = 0; k < 6; k++) begin
            x = 2'($urandom); y = 2'($urandom); cyc();
        end
        en = 1'b0; run(20);
        check_val("endrop_nopkt", rx.size(), 0);
        en = 1'b1;
        for (int k = 0; k < 27; k++) begin
            x = 2'($urandom); y = 2'($urandom); cyc();
        end
        en = 1'b0; run(12);
        check_val("endrop_len", rx.size(), 9);
        if (rx.size() > 0) check_val("endrop_win", rx[0], 0);

        // Clock-gate stall and reset mid-packet
        do_reset();
        wle = 1; en = 1'b1; strobe = 1'b1; ready = 1'b1; x = 2'b01; y = 2'b11;
        run(4);
        en = 1'b0;
        d0 = bpif.bp_data;
        cg = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_val("stall_data", bpif.bp_data, d0);
            check_val("stall_valid", bpif.bp_valid, 1);
        end
        cg = 1'b1; cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check_val("midrst_valid", bpif.bp_valid, 0);
        check_val("midrst_ndropped", ndrop, 0);
        check_val("midrst_busy", busy, 0);
        rx.delete(); wle = 0; en = 1'b1; run(2); en = 1'b0; run(12);
        if (rx.size() > 0) check_val("midrst_win", rx[0], 0);
        else check_val("midrst_len", rx.size(), 9);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            cg     = ($urandom_range(0, 9) != 0);
            strobe = ($urandom_range(0, 2) != 0);
            ready  = ($urandom_range(0, 3) != 0);
            x = 2'($urandom); y = 2'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                en  = ~en;
                one = 1'($urandom_range(0, 1));
                wle = ($urandom_range(0, 9) == 0) ? WW'($urandom_range(0, 31)) : WW'($urandom_range(0, 5));
            end
            rst = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/multi_correlator.md
# multi_correlator

Multi-channel windowed correlator with a byte-stream result port. It counts X, Y, X∩Y and X⊕Y for N_PAIRS independent input pairs over a rectangular window of 2^e samples. At each window end it snapshots all counts into a packet and emits it over a valid/ready byte stream. It sits between the sample-strobe generator and the host-facing register/packet layer, and supports continuous and one-shot capture, input-scaled reporting and explicit drop accounting.

## Interface
- N_PAIRS, 2, number of independent (x,y) input pairs; ≥1.
- MAX_WINDOW_LENGTH_EXP, 16, maximum e; internal count width is MAX_WINDOW_LENGTH_EXP+1; ≥1.
- WLE_W, $clog2(MAX_WINDOW_LENGTH_EXP+1), derived width of window exponent.

Ports:
- i_clk  in  1  clock. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset.
- i_cg  in  1  clock-gate enable; when low, no state changes.
- i_sampleStrobe  in  1  take one sample this cycle (qualified by i_cg).
- i_x  in  N_PAIRS  X inputs, bit p = pair p.
- i_y  in  N_PAIRS  Y inputs.
- i_windowLengthExp  in  WLE_W  e; values above MAX_WINDOW_LENGTH_EXP are clamped to MAX.
- i_enable  in  1  run capture.
- i_oneShot  in  1  capture exactly one window per enable.
- o_bp_data  out  8  packet byte.
- o_bp_valid  out  1  byte valid.
- i_bp_ready  in  1  downstream accepts byte.
- o_busy  out  1  capture running or packet in flight.
- o_nDropped  out  8  count of dropped window packets; saturates at 255.

## Operation
- Capture FSM: IDLE → COUNT when i_enable=1, latching e. COUNT → IDLE when i_enable=0; the partial window is discarded. COUNT → DONE on window end if the latched oneShot=1. DONE → IDLE when i_enable=0.
- In IDLE, t and all counters are held at 0. i_windowLengthExp and i_oneShot are sampled only on the IDLE→COUNT transition.
- Sample: on i_cg && i_sampleStrobe in COUNT, for each pair p: cntX += x[p], cntY += y[p], cntI += x&y, cntS += x^y. t advances by 1.
- Window end: a sample with t == 2^e−1 (e=0: every sample). The counts including that sample are snapshotted, and counters and t clear to 0 in the same cycle. winNum (8-bit, wraps) increments after the snapshot.
- Report scaling per count c: if e≥8, byte = (c >> (e−8)); if e<8, byte = (c << (8−e)). Either way the result saturates to 255, so a full window (c=2^e) reports 255.
- Packet is 1+4·N_PAIRS bytes: winNum (pre-increment value), then for p=0..N−1: X, Y, Isect, Symdiff.
- Emitter FSM: E_IDLE → E_SEND on snapshot. Each byte advances on o_bp_valid && i_bp_ready. After the last byte it returns to E_IDLE.
- The emitter is free if it is in E_IDLE, or if its last byte is accepted in the same cycle. A window end while the emitter is not free drops that packet: o_nDropped increments (saturating), winNum still increments, and the in-flight packet is unaffected.
- Deasserting i_enable never aborts an in-flight packet.
- o_busy = (FSM==COUNT) || (emitter != E_IDLE).

## Timing
- Reset values: o_bp_valid=0, o_bp_data=0, o_busy=0, o_nDropped=0, winNum=0, FSM=IDLE, emitter=E_IDLE, all counters and t = 0.
- Reset mid-packet aborts the packet immediately; o_bp_valid=0 on the next cycle.
- Latency: the window-end strobe is at cycle n; o_bp_valid=1 with the winNum byte at cycle n+1.
- With i_bp_ready held at 1, the packet occupies cycles n+1 … n+1+4·N_PAIRS.
- o_bp_data and o_bp_valid are registered. Once o_bp_valid is high, o_bp_data is stable until accepted.
- i_cg=0 freezes all state, including handshake progress. o_bp_valid holds its value.
- The earliest IDLE→COUNT strobe counts: the first strobe after the enable cycle is sample t=0.

## Test plan
- Back-to-back windows: N_PAIRS=2, e=2, strobe every cycle, ready=1, pair0 x=1,y=0, pair1 x=y=1 on samples 0,2 else 0. Required packet: 00,FF,00,00,FF,80,80,80,00, then the next window emits winNum 01.
- e≥8 scaling: e=10, x=1 on 300 of 1024 samples. Required X byte = 300>>2 = 75 (0x4B). With x=1 on all samples, X byte saturates to 0xFF.
- Drop accounting: e=0, strobe every cycle, i_bp_ready=0. Required: first packet held with winNum 00 valid; o_nDropped counts 1,2,… to 255 and stays; on releasing ready, the next packet carries the current winNum (not 01).
- One-shot: i_oneShot=1, e=3. Required: exactly one packet; o_busy drops after its last byte; no further packets until i_enable toggles 0→1.
- Enable drop mid-window: deassert i_enable at t=5 of e=4. Required: no packet, winNum unchanged; re-enable starts from t=0 with counts 0.
- Stall and reset: i_cg=0 for 3 cycles mid-packet freezes o_bp_data/valid. i_rst mid-packet gives o_bp_valid=0, o_nDropped=0 and winNum=0 next cycle.
